// File: rtl/tensor_mac_array_pkg.sv
// Shared types, FSM encodings and helpers for the tensor MAC array.
package tensor_mac_array_pkg;

  typedef enum logic [1:0] {
    TM_MAC = 2'd0,
    TM_MUL = 2'd1,
    TM_ACC = 2'd2,
    TM_RSV = 2'd3
  } tm_mode_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_COMP = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Bit offset of element [r][c] in a row-major packed matrix of w-bit elements.
  function automatic int elem_lsb(input int r, input int c, input int dim, input int w);
    return (r * dim + c) * w;
  endfunction

  // Clamp a sign-extended sum into the signed acc_w-bit range.
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                   input int acc_w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (acc_w - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/tensor_mac_array_if.sv
// Operand/result handshake bundle between the operand register file, the engine and writeback.
interface tensor_mac_array_if #(
  parameter int DIM   = 4,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                mode;
  logic [DIM*DIM*IN_W-1:0]   matrix_a;
  logic [DIM*DIM*IN_W-1:0]   matrix_b;
  logic [DIM*DIM*ACC_W-1:0]  matrix_c;
  logic                      out_valid;
  logic                      out_ready;
  logic [DIM*DIM*ACC_W-1:0]  matrix_d;
  logic                      ovf;
  logic                      busy;

  modport master (
    output in_valid, mode, matrix_a, matrix_b, matrix_c, out_ready,
    input  in_ready, out_valid, matrix_d, ovf, busy
  );

  modport slave (
    input  in_valid, mode, matrix_a, matrix_b, matrix_c, out_ready,
    output in_ready, out_valid, matrix_d, ovf, busy
  );
endinterface

// File: rtl/tensor_mac_array_row_dot.sv
// One output element: signed DIM-wide dot product of an A row and a B column plus an addend,
// returned at full width so the caller can detect overflow.
module tensor_row_dot #(
  parameter int DIM   = 4,
  parameter int IN_W  = 16,
  parameter int ACC_W = 32,
  parameter int SUM_W = ACC_W + $clog2(DIM) + 1
) (
  input  logic [DIM*IN_W-1:0]      a_row,
  input  logic [DIM*IN_W-1:0]      b_col,
  input  logic signed [ACC_W-1:0]  addend,
  output logic signed [SUM_W-1:0]  sum
);
  localparam int PROD_W = 2 * IN_W;

  logic signed [PROD_W-1:0] prod [DIM];

  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      prod[k] = PROD_W'($signed(a_row[k*IN_W +: IN_W])) *
                PROD_W'($signed(b_col[k*IN_W +: IN_W]));
    end
  end

  always_comb begin
    sum = SUM_W'(addend);
    for (int k = 0; k < DIM; k++) begin
      sum = sum + SUM_W'(prod[k]);
    end
  end
endmodule

// File: rtl/tensor_mac_array.sv
// DIMxDIM signed matrix multiply-accumulate engine: D = A*B (+C | +D_prev), one row per cycle,
// with wrap or saturate arithmetic and a sticky overflow flag.
module tensor_mac_array
  import tensor_mac_array_pkg::*;
#(
  parameter int DIM      = 4,
  parameter int IN_W     = 16,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              reset,
  tensor_mac_array_if.slave bus
);
  localparam int SUM_W   = ACC_W + $clog2(DIM) + 1;
  localparam int ROW_W   = $clog2(DIM);
  localparam int ROW_IN  = DIM * IN_W;
  localparam int ROW_ACC = DIM * ACC_W;

  logic [1:0]               rst_sync;
  logic                     rst_ok;
  logic [1:0]               state;
  logic [ROW_W-1:0]         row;
  tm_mode_e                 mode_q;
  logic [DIM*DIM*IN_W-1:0]  a_q;
  logic [DIM*DIM*IN_W-1:0]  b_q;
  logic [DIM*DIM*ACC_W-1:0] c_q;
  logic [DIM*DIM*ACC_W-1:0] d_q;
  logic                     ovf_q;
  logic                     in_ready;
  logic                     accept;
  logic                     last_row;
  logic [ROW_IN-1:0]        a_row;
  logic [ROW_ACC-1:0]       c_row;
  logic [ROW_ACC-1:0]       d_row;
  logic [ROW_ACC-1:0]       row_res;
  logic [DIM-1:0]           row_ovf;

  // Reset asserts asynchronously but releases two clocks later so no flop sees a runt release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_sync <= 2'b00;
    end else begin
      rst_sync <= {rst_sync[0], 1'b1};
    end
  end

  assign rst_ok   = rst_sync[1];
  assign in_ready = rst_ok & ((state == S_IDLE) | ((state == S_HOLD) & bus.out_ready));
  assign accept   = bus.in_valid & in_ready;
  assign last_row = (row == ROW_W'(DIM - 1));

  assign a_row = a_q[elem_lsb(int'(row), 0, DIM, IN_W) +: ROW_IN];
  assign c_row = c_q[elem_lsb(int'(row), 0, DIM, ACC_W) +: ROW_ACC];
  // Row r of d_q is only overwritten while computing row r, so it still holds D_prev here.
  assign d_row = d_q[elem_lsb(int'(row), 0, DIM, ACC_W) +: ROW_ACC];

  for (genvar c = 0; c < DIM; c++) begin : g_col
    logic [ROW_IN-1:0]       b_col;
    logic signed [ACC_W-1:0] addend;
    logic signed [SUM_W-1:0] sum;
    logic signed [63:0]      sum_ext;
    logic signed [63:0]      clamped;

    for (genvar k = 0; k < DIM; k++) begin : g_k
      assign b_col[k*IN_W +: IN_W] = b_q[elem_lsb(k, c, DIM, IN_W) +: IN_W];
    end

    always_comb begin
      case (mode_q)
        TM_MAC:  addend = c_row[c*ACC_W +: ACC_W];
        TM_ACC:  addend = d_row[c*ACC_W +: ACC_W];
        default: addend = '0;
      endcase
    end

    tensor_row_dot #(
      .DIM   (DIM),
      .IN_W  (IN_W),
      .ACC_W (ACC_W),
      .SUM_W (SUM_W)
    ) u_dot (
      .a_row  (a_row),
      .b_col  (b_col),
      .addend (addend),
      .sum    (sum)
    );

    assign sum_ext    = 64'(sum);
    assign clamped    = sat_clamp(sum_ext, ACC_W);
    assign row_ovf[c] = (clamped != sum_ext);
    assign row_res[c*ACC_W +: ACC_W] = (SATURATE != 0) ? clamped[ACC_W-1:0]
                                                       : sum_ext[ACC_W-1:0];
  end

  // Accept can only fire from IDLE or from HOLD when the result is being taken.
  always_ff @(posedge clk or negedge rst_ok) begin
    if (!rst_ok) begin
      state  <= S_IDLE;
      row    <= '0;
      mode_q <= TM_MAC;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q    <= bus.matrix_a;
      b_q    <= bus.matrix_b;
      c_q    <= bus.matrix_c;
      mode_q <= tm_mode_e'(bus.mode);
      ovf_q  <= 1'b0;
      row    <= '0;
      state  <= S_COMP;
    end else begin
      case (state)
        S_COMP: begin
          d_q[elem_lsb(int'(row), 0, DIM, ACC_W) +: ROW_ACC] <= row_res;
          if (|row_ovf) begin
            ovf_q <= 1'b1;
          end
          row <= row + ROW_W'(1);
          if (last_row) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state == S_HOLD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.matrix_d  = d_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_tensor_mac_array.sv
// Directed bench: 4x4 saturating and wrapping engines in lockstep plus a 2x2/8/20 engine.
module tb_tensor_mac_array;
  import tensor_mac_array_pkg::*;

  typedef logic [255:0] m4i_t;
  typedef logic [511:0] m4a_t;

  typedef struct packed {
    logic [1:0] mode;
    m4i_t       a;
    m4i_t       b;
    m4a_t       c;
    m4a_t       d_sat;
    m4a_t       d_wrap;
    logic       ovf;
  } vec4_t;

  typedef struct packed {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [79:0] c;
    logic [79:0] d;
    logic        ovf;
  } vec2_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec4_t v4 [6];
  vec2_t v2 [5];

  always #5 clk = ~clk;

  tensor_mac_array_if #(.DIM(4), .IN_W(16), .ACC_W(32)) if4s ();
  tensor_mac_array_if #(.DIM(4), .IN_W(16), .ACC_W(32)) if4w ();
  tensor_mac_array_if #(.DIM(2), .IN_W(8),  .ACC_W(20)) if2 ();

  tensor_mac_array #(.DIM(4), .IN_W(16), .ACC_W(32), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .bus(if4s));
  tensor_mac_array #(.DIM(4), .IN_W(16), .ACC_W(32), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .bus(if4w));
  tensor_mac_array #(.DIM(2), .IN_W(8), .ACC_W(20), .SATURATE(1)) u_small (
    .clk(clk), .reset(reset), .bus(if2));

  // The wrapping engine sees exactly the same traffic as the saturating one.
  assign if4w.in_valid  = if4s.in_valid;
  assign if4w.mode      = if4s.mode;
  assign if4w.matrix_a  = if4s.matrix_a;
  assign if4w.matrix_b  = if4s.matrix_b;
  assign if4w.matrix_c  = if4s.matrix_c;
  assign if4w.out_ready = if4s.out_ready;

  function automatic m4i_t ident4();
    m4i_t m = '0;
    for (int i = 0; i < 4; i++) m[(i*4+i)*16 +: 16] = 16'd1;
    return m;
  endfunction

  function automatic vec4_t mk4(input logic [1:0] mode, input m4i_t a, input m4i_t b,
                                input m4a_t c, input m4a_t ds, input m4a_t dw, input logic ovf);
    vec4_t v;
    v.mode = mode; v.a = a; v.b = b; v.c = c; v.d_sat = ds; v.d_wrap = dw; v.ovf = ovf;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic waitValid4(output int lat);
    lat = 1;
    while (!if4s.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic applyStimulus4(input logic [1:0] mode, input m4i_t a, input m4i_t b,
                                input m4a_t c, output int lat);
    if4s.mode = mode; if4s.matrix_a = a; if4s.matrix_b = b; if4s.matrix_c = c;
    if4s.in_valid = 1'b1;
    checkOutput("in_ready before accept", 512'(if4s.in_ready), 512'(1));
    step();
    if4s.in_valid = 1'b0;
    waitValid4(lat);
  endtask

  task automatic release4();
    if4s.out_ready = 1'b1;
    step();
    if4s.out_ready = 1'b0;
  endtask

  task automatic applyStimulus2(input vec2_t v, output int lat);
    if2.mode = v.mode; if2.matrix_a = v.a; if2.matrix_b = v.b; if2.matrix_c = v.c;
    if2.in_valid = 1'b1;
    step();
    if2.in_valid = 1'b0;
    lat = 1;
    while (!if2.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   lat;
    m4i_t fa, fb;
    m4a_t fd;

    if4s.in_valid = 1'b0; if4s.mode = 2'd0; if4s.out_ready = 1'b0;
    if4s.matrix_a = '0; if4s.matrix_b = '0; if4s.matrix_c = '0;
    if2.in_valid = 1'b0; if2.mode = 2'd0; if2.out_ready = 1'b0;
    if2.matrix_a = '0; if2.matrix_b = '0; if2.matrix_c = '0;

    fa = '0; fb = '0; fd = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        fa[(r*4+c)*16 +: 16] = 16'(r + c);
        fb[(r*4+c)*16 +: 16] = 16'(r - c);
        fd[(r*4+c)*32 +: 32] = 32'(6*r - 4*r*c + 14 - 6*c);
      end
    end

    v4[0] = mk4(2'd0, ident4(), {16{16'h0002}}, {16{32'd5}},
                {16{32'd7}}, {16{32'd7}}, 1'b0);
    v4[1] = mk4(2'd1, fa, fb, {16{32'h7FFF_FFFF}}, fd, fd, 1'b0);
    v4[2] = mk4(2'd0, {16{16'h7FFF}}, {16{16'h7FFF}}, {16{32'h7FFF_FFFF}},
                {16{32'h7FFF_FFFF}}, {16{32'h7FFC_0003}}, 1'b1);
    v4[3] = mk4(2'd0, {16{16'h8000}}, {16{16'h7FFF}}, {16{32'h8000_0000}},
                {16{32'h8000_0000}}, {16{32'h8002_0000}}, 1'b1);
    v4[4] = mk4(2'd3, ident4(), {16{16'h0002}}, {16{32'd5}},
                {16{32'd2}}, {16{32'd2}}, 1'b0);
    v4[5] = mk4(2'd2, ident4(), {16{16'h0003}}, {16{32'd100}},
                {16{32'd5}}, {16{32'd5}}, 1'b0);

    v2[0] = '{mode: 2'd0, a: 32'h0100_0001, b: {4{8'h02}}, c: {4{20'd5}},
              d: {4{20'd7}}, ovf: 1'b0};
    v2[1] = '{mode: 2'd1, a: 32'h0403_0201, b: 32'h0807_0605, c: {4{20'h7FFFF}},
              d: {20'd50, 20'd43, 20'd22, 20'd19}, ovf: 1'b0};
    v2[2] = '{mode: 2'd0, a: {4{8'h7F}}, b: {4{8'h7F}}, c: {4{20'h7FFFF}},
              d: {4{20'h7FFFF}}, ovf: 1'b1};
    v2[3] = '{mode: 2'd0, a: {4{8'h80}}, b: {4{8'h7F}}, c: {4{20'h80000}},
              d: {4{20'h80000}}, ovf: 1'b1};
    v2[4] = '{mode: 2'd2, a: 32'h0100_0001, b: {4{8'h03}}, c: {4{20'd1}},
              d: {4{20'h80003}}, ovf: 1'b0};

    #2 reset = 1'b0;
    #1;
    checkOutput("reset out_valid", 512'(if4s.out_valid), 512'(0));
    checkOutput("reset busy", 512'(if4s.busy), 512'(0));
    checkOutput("reset ovf", 512'(if4s.ovf), 512'(0));
    checkOutput("reset matrix_d", if4s.matrix_d, '0);
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    checkOutput("in_ready after release", 512'(if4s.in_ready), 512'(1));
    checkOutput("small in_ready after release", 512'(if2.in_ready), 512'(1));

    for (int i = 0; i < 6; i++) begin
      applyStimulus4(v4[i].mode, v4[i].a, v4[i].b, v4[i].c, lat);
      checkOutput($sformatf("v4[%0d] latency", i), 512'(lat), 512'(5));
      checkOutput($sformatf("v4[%0d] d_sat", i), if4s.matrix_d, v4[i].d_sat);
      checkOutput($sformatf("v4[%0d] d_wrap", i), if4w.matrix_d, v4[i].d_wrap);
      checkOutput($sformatf("v4[%0d] ovf_sat", i), 512'(if4s.ovf), 512'(v4[i].ovf));
      checkOutput($sformatf("v4[%0d] ovf_wrap", i), 512'(if4w.ovf), 512'(v4[i].ovf));
      release4();
    end

    // in_valid during COMP must be ignored.
    if4s.mode = 2'd0; if4s.matrix_a = ident4(); if4s.matrix_b = {16{16'h0002}};
    if4s.matrix_c = {16{32'd5}}; if4s.in_valid = 1'b1;
    step();
    if4s.mode = 2'd1; if4s.matrix_a = {16{16'h0009}};
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("comp%0d in_ready", k), 512'(if4s.in_ready), 512'(0));
      checkOutput($sformatf("comp%0d busy", k), 512'(if4s.busy), 512'(1));
      step();
    end
    checkOutput("ignore out_valid", 512'(if4s.out_valid), 512'(1));
    checkOutput("ignore matrix_d", if4s.matrix_d, {16{32'd7}});
    checkOutput("ignore hold in_ready", 512'(if4s.in_ready), 512'(0));
    if4s.in_valid = 1'b0;
    release4();
    checkOutput("idle busy", 512'(if4s.busy), 512'(0));
    checkOutput("idle out_valid", 512'(if4s.out_valid), 512'(0));

    // Back-to-back ACC with a stalled consumer on the second result.
    doReset();
    if4s.mode = 2'd2; if4s.matrix_a = ident4(); if4s.matrix_b = {16{16'h0001}};
    if4s.matrix_c = {16{32'd50}}; if4s.in_valid = 1'b1; if4s.out_ready = 1'b1;
    step();
    waitValid4(lat);
    checkOutput("acc1 matrix_d", if4s.matrix_d, {16{32'd1}});
    checkOutput("acc1 in_ready", 512'(if4s.in_ready), 512'(1));
    step();
    if4s.out_ready = 1'b0;
    waitValid4(lat);
    checkOutput("acc2 latency", 512'(lat), 512'(5));
    checkOutput("acc2 matrix_d", if4s.matrix_d, {16{32'd2}});
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput($sformatf("acc2 hold%0d out_valid", k), 512'(if4s.out_valid), 512'(1));
      checkOutput($sformatf("acc2 hold%0d in_ready", k), 512'(if4s.in_ready), 512'(0));
      checkOutput($sformatf("acc2 hold%0d matrix_d", k), if4s.matrix_d, {16{32'd2}});
    end
    if4s.out_ready = 1'b1;
    #1;
    checkOutput("acc2 release in_ready", 512'(if4s.in_ready), 512'(1));
    step();
    if4s.in_valid = 1'b0; if4s.out_ready = 1'b0;
    waitValid4(lat);
    checkOutput("acc3 matrix_d", if4s.matrix_d, {16{32'd3}});
    release4();

    // Reset in the second COMP cycle aborts the operation at once.
    if4s.mode = 2'd0; if4s.matrix_a = ident4(); if4s.matrix_b = {16{16'h0002}};
    if4s.matrix_c = {16{32'd5}}; if4s.in_valid = 1'b1;
    step();
    if4s.in_valid = 1'b0;
    step();
    reset = 1'b0;
    #1;
    checkOutput("abort out_valid", 512'(if4s.out_valid), 512'(0));
    checkOutput("abort busy", 512'(if4s.busy), 512'(0));
    checkOutput("abort matrix_d", if4s.matrix_d, '0);
    step();
    step();
    reset = 1'b1;
    repeat (3) step();
    applyStimulus4(2'd2, ident4(), {16{16'h0004}}, {16{32'd9}}, lat);
    checkOutput("post-reset acc latency", 512'(lat), 512'(5));
    checkOutput("post-reset acc matrix_d", if4s.matrix_d, {16{32'd4}});
    release4();

    for (int i = 0; i < 5; i++) begin
      applyStimulus2(v2[i], lat);
      checkOutput($sformatf("v2[%0d] latency", i), 512'(lat), 512'(3));
      checkOutput($sformatf("v2[%0d] matrix_d", i), 512'(if2.matrix_d), 512'(v2[i].d));
      checkOutput($sformatf("v2[%0d] ovf", i), 512'(if2.ovf), 512'(v2[i].ovf));
      if2.out_ready = 1'b1;
      step();
      if2.out_ready = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
